// File: rtl/common_types_pkg.sv
// Shared types and constants for the GNSS epoch event unit.
//  - Register word offsets (decoded from haddr[7:0] with the byte bits dropped)
//  - AHB transfer / response encodings used by the satellite
//  - gnss_cr_t: packed view of the control register fields
//  - cr_to_word(): places the control fields back at their bus bit positions
package common_types_pkg;

  localparam logic [7:0] OFS_STATUS   = 8'h00;
  localparam logic [7:0] OFS_CR       = 8'h04;
  localparam logic [7:0] OFS_MASK     = 8'h08;
  localparam logic [7:0] OFS_OVERRUN  = 8'h0C;
  localparam logic [7:0] OFS_TSTAMP   = 8'h10;
  localparam logic [7:0] OFS_SNAP_TS  = 8'h14;
  localparam logic [7:0] OFS_SNAP_CMD = 8'h18;

  localparam logic       HRESP_OKAY   = 1'b0;

  typedef struct packed {
    logic        en;
    logic        snap_auto;
    logic [4:0]  snap_src;
    logic [15:0] snap_div;
  } gnss_cr_t;

  // Bus layout: bit0 EN, bit1 SNAP_AUTO, [12:8] SNAP_SRC, [31:16] SNAP_DIV.
  function automatic logic [31:0] cr_to_word(input gnss_cr_t c);
    return {c.snap_div, 3'b000, c.snap_src, 6'b000000, c.snap_auto, c.en};
  endfunction

endpackage

// File: rtl/ahb_bus_if.sv
// Minimal AHB-Lite bus bundle between a master/multiplexor and a satellite.
//  satellite modport: hsel, haddr, htrans, hwrite, hwdata in;
//                     hrdata, hready, hresp out.
interface ahb_bus_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport satellite (
    input  hsel, haddr, htrans, hwrite, hwdata,
    output hrdata, hready, hresp
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hwdata,
    input  hrdata, hready, hresp
  );
endinterface

// File: rtl/gnss_snapshot_gen.sv
// Snapshot generator: counts epochs of the selected source channel, merges the
// auto trigger with software requests into one pulse, and latches the
// timestamp seen while the pulse is high.
//  clk, rst  : clock, async active-high reset
//  cr        : current control register
//  cr_wr     : CR is being written this cycle (clears the divider counter)
//  sw_req    : software snapshot request this cycle
//  epoch     : per-channel epoch events
//  tstamp    : free-running timestamp
//  snapshot  : registered single-cycle pulse
//  snap_ts   : timestamp captured during the last pulse
module gnss_snapshot_gen
  import common_types_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int TS_WIDTH  = 32,
  parameter int DIV_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  gnss_cr_t            cr,
  input  logic                cr_wr,
  input  logic                sw_req,
  input  logic [NUM_CH-1:0]   epoch,
  input  logic [TS_WIDTH-1:0] tstamp,
  output logic                snapshot,
  output logic [TS_WIDTH-1:0] snap_ts
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 snap_q, snap_d;
  logic [TS_WIDTH-1:0]  snap_ts_q, snap_ts_d;

  logic [31:0]          epoch_ext;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH:0]   cnt_inc;
  logic                 src_hit;
  logic                 auto_fire;

  always_comb begin
    // Widen so any 5-bit source index is legal; channels beyond NUM_CH are 0.
    epoch_ext = 32'(epoch);
    div_eff   = cr.snap_div[DIV_WIDTH-1:0];
    if (div_eff == '0) div_eff = DIV_WIDTH'(1);

    src_hit   = cr.en && cr.snap_auto && (int'(cr.snap_src) < NUM_CH) &&
                epoch_ext[cr.snap_src];
    // One extra bit so the compare is exact even at the maximum divider.
    cnt_inc   = {1'b0, cnt_q} + (DIV_WIDTH+1)'(1);
    auto_fire = src_hit && (cnt_inc >= {1'b0, div_eff});

    cnt_d = cnt_q;
    if (src_hit) cnt_d = auto_fire ? '0 : cnt_inc[DIV_WIDTH-1:0];
    if (cr_wr)   cnt_d = '0;

    // Software and auto triggers in the same cycle merge into one pulse.
    snap_d    = auto_fire | sw_req;
    snap_ts_d = snap_q ? tstamp : snap_ts_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      snap_q    <= 1'b0;
      snap_ts_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      snap_ts_q <= snap_ts_d;
    end
  end

  assign snapshot = snap_q;
  assign snap_ts  = snap_ts_q;

endmodule

// File: rtl/gnss_epoch_event_unit.sv
// GNSS epoch event unit: AHB satellite collecting per-channel epoch events.
// Holds sticky STATUS (W1C), OVERRUN (W1C), MASK, CR, the free-running
// TSTAMP and the registered interrupt; snapshot logic lives in
// gnss_snapshot_gen.
//  clk, rst : clock, async active-high reset
//  abif     : AHB satellite port (zero wait state, always OKAY)
//  epoch    : per-channel epoch events, one event per high cycle
//  snapshot : single-cycle snapshot pulse to the correlators
//  irq      : registered |(STATUS & MASK)
module gnss_epoch_event_unit
  import common_types_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int TS_WIDTH  = 32,
  parameter int DIV_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  ahb_bus_if.satellite      abif,
  input  logic [NUM_CH-1:0] epoch,
  output logic              snapshot,
  output logic              irq
);

  localparam logic [15:0] DIV_MASK = 16'((32'd1 << DIV_WIDTH) - 32'd1);

  logic                dp_valid_q, dp_valid_d;
  logic                dp_write_q, dp_write_d;
  logic [7:0]          dp_addr_q,  dp_addr_d;
  logic [NUM_CH-1:0]   status_q,   status_d;
  logic [NUM_CH-1:0]   ovr_q,      ovr_d;
  logic [NUM_CH-1:0]   mask_q,     mask_d;
  gnss_cr_t            cr_q,       cr_d;
  logic [TS_WIDTH-1:0] tstamp_q,   tstamp_d;
  logic                irq_q,      irq_d;

  logic                wr, wr_status, wr_ovr, wr_mask, wr_cr, sw_req;
  logic [NUM_CH-1:0]   wdata_ch, epoch_en, status_w1c, ovr_w1c;
  logic [31:0]         rdata;
  logic [TS_WIDTH-1:0] snap_ts;
  logic                unused_bits;

  always_comb begin
    // Address phase capture; hready is always 1 so every selected
    // NONSEQ/SEQ transfer is accepted.
    dp_valid_d = abif.hsel && abif.htrans[1];
    dp_write_d = abif.hwrite;
    dp_addr_d  = {abif.haddr[7:2], 2'b00};

    wr        = dp_valid_q && dp_write_q;
    wr_status = wr && (dp_addr_q == OFS_STATUS);
    wr_cr     = wr && (dp_addr_q == OFS_CR);
    wr_mask   = wr && (dp_addr_q == OFS_MASK);
    wr_ovr    = wr && (dp_addr_q == OFS_OVERRUN);
    sw_req    = wr && (dp_addr_q == OFS_SNAP_CMD) && abif.hwdata[0];
    wdata_ch  = abif.hwdata[NUM_CH-1:0];

    epoch_en   = cr_q.en ? epoch : '0;
    status_w1c = wr_status ? wdata_ch : '0;
    ovr_w1c    = wr_ovr    ? wdata_ch : '0;

    // Set beats clear; an epoch landing on a bit being cleared is not
    // an overrun.
    status_d = (status_q & ~status_w1c) | epoch_en;
    ovr_d    = (ovr_q & ~ovr_w1c) | (epoch_en & status_q & ~status_w1c);
    mask_d   = wr_mask ? wdata_ch : mask_q;

    cr_d = cr_q;
    if (wr_cr) begin
      cr_d.en        = abif.hwdata[0];
      cr_d.snap_auto = abif.hwdata[1];
      cr_d.snap_src  = abif.hwdata[12:8];
      cr_d.snap_div  = abif.hwdata[31:16] & DIV_MASK;
    end

    tstamp_d = tstamp_q + TS_WIDTH'(1);
    irq_d    = |(status_q & mask_q);

    // Read mux returns the current (pre-update) register contents.
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        OFS_STATUS:  rdata = 32'(status_q);
        OFS_CR:      rdata = cr_to_word(cr_q);
        OFS_MASK:    rdata = 32'(mask_q);
        OFS_OVERRUN: rdata = 32'(ovr_q);
        OFS_TSTAMP:  rdata = 32'(tstamp_q);
        OFS_SNAP_TS: rdata = 32'(snap_ts);
        default:     rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      status_q   <= '0;
      ovr_q      <= '0;
      mask_q     <= '0;
      cr_q       <= '0;
      tstamp_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      status_q   <= status_d;
      ovr_q      <= ovr_d;
      mask_q     <= mask_d;
      cr_q       <= cr_d;
      tstamp_q   <= tstamp_d;
      irq_q      <= irq_d;
    end
  end

  gnss_snapshot_gen #(
    .NUM_CH    (NUM_CH),
    .TS_WIDTH  (TS_WIDTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_snap (
    .clk      (clk),
    .rst      (rst),
    .cr       (cr_q),
    .cr_wr    (wr_cr),
    .sw_req   (sw_req),
    .epoch    (epoch),
    .tstamp   (tstamp_q),
    .snapshot (snapshot),
    .snap_ts  (snap_ts)
  );

  assign abif.hrdata = rdata;
  assign abif.hready = 1'b1;
  assign abif.hresp  = HRESP_OKAY;
  assign irq         = irq_q;

  // Address/data bits that carry no meaning for this block.
  assign unused_bits = ^{abif.haddr[31:8], abif.haddr[1:0], abif.htrans[0],
                         abif.hwdata};

endmodule

// File: tb/tb_gnss_epoch_event_unit.sv
module tb_gnss_epoch_event_unit;

  localparam bit [31:0] BASE = 32'h0004_0000;
  localparam bit [31:0] CHM  = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] epoch = '0;
  logic        snapshot;
  logic        irq;

  ahb_bus_if bus();

  always #5 clk = ~clk;

  gnss_epoch_event_unit #(.NUM_CH(16), .TS_WIDTH(32), .DIV_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .abif     (bus),
    .epoch    (epoch),
    .snapshot (snapshot),
    .irq      (irq)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of the register file, advanced once per clock.
  bit [31:0] m_status, m_ovr, m_mask, m_ts, m_snap_ts;
  bit        m_en, m_auto, m_snap, m_irq;
  int        m_src, m_div, m_cnt;
  bit        dp_valid, dp_write;
  bit [7:0]  dp_addr;
  int        n_pulse_obs;
  bit [31:0] last_pulse_ts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] exp_read(input bit [7:0] a);
    bit [31:0] d;
    bit [15:0] dv;
    bit [4:0]  sv;
    dv = m_div[15:0];
    sv = m_src[4:0];
    case (a)
      8'h00:   d = m_status;
      8'h04:   d = {dv, 3'b000, sv, 6'b000000, m_auto, m_en};
      8'h08:   d = m_mask;
      8'h0C:   d = m_ovr;
      8'h10:   d = m_ts;
      8'h14:   d = m_snap_ts;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    m_status = 0; m_ovr = 0; m_mask = 0; m_ts = 0; m_snap_ts = 0;
    m_en = 0; m_auto = 0; m_snap = 0; m_irq = 0;
    m_src = 0; m_div = 0; m_cnt = 0;
    dp_valid = 0; dp_write = 0; dp_addr = 0;
  endtask

  // Apply this cycle's events to the model, advance one clock, then compare
  // the registered outputs.
  task automatic tick();
    bit        wr, fire, sw, ni;
    bit [31:0] wd, w1c_s, w1c_o, ep, ns, no;
    int        dv;
    wr    = dp_valid && dp_write;
    wd    = bus.hwdata;
    w1c_s = (wr && dp_addr == 8'h00) ? (wd & CHM) : 32'h0;
    w1c_o = (wr && dp_addr == 8'h0C) ? (wd & CHM) : 32'h0;
    ep    = m_en ? 32'(epoch) : 32'h0;
    ns    = (m_status & ~w1c_s) | ep;
    no    = (m_ovr & ~w1c_o) | (ep & m_status & ~w1c_s);
    ni    = (m_status & m_mask) != 0;
    fire  = 0;
    dv    = (m_div == 0) ? 1 : m_div;
    if (m_en && m_auto && m_src < 16 && ep[m_src]) begin
      m_cnt++;
      if (m_cnt >= dv) begin
        fire  = 1;
        m_cnt = 0;
      end
    end
    sw = wr && dp_addr == 8'h18 && wd[0];
    if (m_snap) m_snap_ts = m_ts;
    m_snap   = fire || sw;
    m_status = ns;
    m_ovr    = no;
    m_irq    = ni;
    if (wr && dp_addr == 8'h08) m_mask = wd & CHM;
    if (wr && dp_addr == 8'h04) begin
      m_en   = wd[0];
      m_auto = wd[1];
      m_src  = int'(wd[12:8]);
      m_div  = int'(wd[31:16]);
      m_cnt  = 0;
    end
    m_ts++;
    dp_valid = bus.hsel && bus.htrans[1];
    dp_write = bus.hwrite;
    dp_addr  = {bus.haddr[7:2], 2'b00};
    @(posedge clk);
    #1;
    if (snapshot === 1'b1) begin
      n_pulse_obs++;
      last_pulse_ts = m_ts;
    end
    chk("snapshot", snapshot, m_snap);
    chk("irq", irq, m_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input bit [15:0] ep);
    epoch = ep;
    tick();
    epoch = '0;
    $display("epoch 0x%04h", ep);
  endtask

  task automatic ahb_wr(input bit [7:0] a, input bit [31:0] d, input bit [15:0] ep);
    bus.hsel = 1; bus.htrans = 2'b10; bus.hwrite = 1; bus.haddr = BASE | 32'(a);
    tick();
    bus.hsel = 0; bus.htrans = 2'b00; bus.hwrite = 0; bus.haddr = 0;
    bus.hwdata = d; epoch = ep;
    tick();
    epoch = '0; bus.hwdata = 0;
    $display("wr 0x%02h <- 0x%08h epoch=0x%04h", a, d, ep);
  endtask

  task automatic ahb_rd(input bit [7:0] a, input string tag, output logic [31:0] val);
    bus.hsel = 1; bus.htrans = 2'b10; bus.hwrite = 0; bus.haddr = BASE | 32'(a);
    tick();
    bus.hsel = 0; bus.htrans = 2'b00; bus.haddr = 0;
    #1;
    val = bus.hrdata;
    chk(tag, val, exp_read(dp_addr));
    chk("hready", bus.hready, 32'h1);
    chk("hresp", bus.hresp, 32'h0);
    $display("rd 0x%02h -> 0x%08h", a, val);
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    bus.hsel = 0; bus.htrans = 0; bus.hwrite = 0; bus.haddr = 0; bus.hwdata = 0;
    epoch = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit   [31:0] rnd;
    bus.hsel = 0; bus.htrans = 0; bus.hwrite = 0; bus.haddr = 0; bus.hwdata = 0;
    model_reset();
    do_reset();

    // Reset state
    chk("rst_snapshot", snapshot, 32'h0);
    chk("rst_irq", irq, 32'h0);
    chk("rst_hrdata", bus.hrdata, 32'h0);
    chk("rst_hready", bus.hready, 32'h1);
    for (int a = 0; a <= 8'h20; a += 4) begin
      ahb_rd(8'(a), "rst_read", v);
      if (a != 8'h10) chk("rst_zero", v, 32'h0);
    end

    // Sticky STATUS and W1C
    ahb_wr(8'h04, 32'h1, 16'h0);
    pulse(16'h2139);
    ahb_rd(8'h00, "status", v);
    chk("status_sticky", v, 32'h2139);
    ahb_wr(8'h00, 32'h39, 16'h0);
    ahb_rd(8'h00, "status", v);
    chk("status_w1c", v, 32'h2100);

    // Disabled channel collection
    ahb_wr(8'h04, 32'h0, 16'h0);
    ahb_wr(8'h00, 32'hFFFF, 16'h0);
    pulse(16'h0001);
    ahb_rd(8'h00, "status", v);
    chk("status_disabled", v, 32'h0);

    // Overrun
    ahb_wr(8'h04, 32'h1, 16'h0);
    ahb_wr(8'h0C, 32'hFFFF, 16'h0);
    pulse(16'h0001);
    pulse(16'h0001);
    ahb_rd(8'h0C, "overrun", v);
    chk("overrun_set", v, 32'h1);

    // Set and W1C collide: set wins, no overrun
    ahb_wr(8'h0C, 32'hFFFF, 16'h0);
    ahb_wr(8'h00, 32'h1, 16'h0001);
    ahb_rd(8'h00, "status", v);
    chk("collide_status", v, 32'h1);
    ahb_rd(8'h0C, "overrun", v);
    chk("collide_overrun", v, 32'h0);

    // Interrupt latency
    ahb_wr(8'h00, 32'hFFFF, 16'h0);
    ahb_wr(8'h08, 32'h0100, 16'h0);
    idle(2);
    epoch = 16'h0100;
    tick();
    epoch = '0;
    chk("irq_t1", irq, 32'h0);
    tick();
    chk("irq_t2", irq, 32'h1);
    ahb_wr(8'h00, 32'h0100, 16'h0);
    chk("irq_clr_t1", irq, 32'h1);
    tick();
    chk("irq_clr_t2", irq, 32'h0);

    // Auto snapshot: SRC=3, DIV=4
    ahb_wr(8'h08, 32'h0, 16'h0);
    ahb_wr(8'h04, 32'h0004_0303, 16'h0);
    n_pulse_obs = 0;
    for (int i = 0; i < 4; i++) begin
      pulse(16'h0008);
      idle(1);
    end
    idle(2);
    chk("auto_four", n_pulse_obs, 32'd1);
    ahb_rd(8'h14, "snap_ts", v);
    chk("snap_ts_match", v, last_pulse_ts);
    n_pulse_obs = 0;
    for (int i = 0; i < 3; i++) pulse(16'h0008);
    idle(3);
    chk("auto_three", n_pulse_obs, 32'd0);
    ahb_wr(8'h18, 32'h1, 16'h0008);
    idle(3);
    chk("auto_sw_merge", n_pulse_obs, 32'd1);

    // Source beyond NUM_CH never fires; DIV=0 acts as 1
    n_pulse_obs = 0;
    ahb_wr(8'h04, 32'h0000_1003, 16'h0);
    for (int i = 0; i < 3; i++) pulse(16'hFFFF);
    idle(2);
    chk("src_out_of_range", n_pulse_obs, 32'd0);
    ahb_wr(8'h04, 32'h0000_0103, 16'h0);
    pulse(16'h0002);
    idle(2);
    chk("div_zero", n_pulse_obs, 32'd1);

    // Software snapshot alone
    n_pulse_obs = 0;
    ahb_wr(8'h18, 32'h1, 16'h0);
    idle(2);
    chk("sw_snapshot", n_pulse_obs, 32'd1);
    ahb_rd(8'h14, "snap_ts", v);
    chk("sw_snap_ts", v, last_pulse_ts);
    ahb_rd(8'h18, "snap_cmd_rd", v);

    // Reset during the data phase of a MASK write aborts it
    bus.hsel = 1; bus.htrans = 2'b10; bus.hwrite = 1; bus.haddr = BASE | 32'h08;
    tick();
    bus.hsel = 0; bus.htrans = 0; bus.hwrite = 0; bus.hwdata = 32'hFFFF;
    do_reset();
    ahb_rd(8'h08, "mask_after_abort", v);
    chk("abort_mask", v, 32'h0);
    ahb_wr(8'h08, 32'h00A5, 16'h0);
    ahb_rd(8'h08, "mask_after_abort", v);
    chk("post_abort_mask", v, 32'h00A5);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      rnd = $urandom & $urandom & CHM;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          for (int k = 0; k < int'($urandom_range(1, 4)); k++)
            pulse(16'($urandom & $urandom & CHM));
        end
        3: ahb_wr(8'h04, {16'($urandom_range(0, 5)), 3'b000,
                          5'($urandom_range(0, 19)), 6'b000000,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 5) != 0)}, 16'(rnd));
        4: ahb_wr(8'h00, $urandom, 16'(rnd));
        5: ahb_wr(8'h0C, $urandom, 16'(rnd));
        6: ahb_wr(8'h08, $urandom, 16'(rnd));
        7: ahb_wr(8'h18, 32'($urandom_range(0, 1)), 16'(rnd));
        default: ahb_rd(8'($urandom_range(0, 8) * 4), "rand_read", v);
      endcase
    end
    for (int a = 0; a <= 8'h18; a += 4) ahb_rd(8'(a), "final_read", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
